// File: rtl/dmem_pkg.sv
// Shared types and widths for the data-memory responder and its storage array.
package dmem_pkg;

  localparam int WORD_W     = 32;
  localparam int BYTE_OFF_W = 2;
  localparam int IDX_FULL_W = WORD_W - BYTE_OFF_W;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } dmem_state_e;

endpackage

// File: rtl/dmem_array.sv
// Word-addressed storage: synchronous write, combinational read, never reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int IDX_W       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  idx_i,
  input  logic [WORD_W-1:0] wdata_i,
  output logic [WORD_W-1:0] rdata_o
);

  logic [WORD_W-1:0] mem_q [DEPTH_WORDS];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[idx_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/dmem_responder.sv
// Memory-side end of the data port: accepts one access, waits LATENCY cycles,
// then returns a one-cycle response with read data or an error flag.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        ready_o,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [7:0] CNT_LOAD = 8'(LATENCY - 1);
  // One extra bit so DEPTH_WORDS = 2^30 still compares against the full index.
  localparam logic [IDX_FULL_W:0] DEPTH_LIM = (IDX_FULL_W + 1)'(DEPTH_WORDS);

  dmem_state_e       state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              ready_q, ready_d;
  logic              rvalid_q, rvalid_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  logic              accept;
  logic              enter_resp;
  logic              cur_we;
  logic [31:0]       cur_addr;
  logic [31:0]       cur_wdata;
  logic              cur_err;
  logic              mem_we;
  logic [WORD_W-1:0] mem_rdata;

  assign accept = req_i && ready_q;

  // With LATENCY=1 the access happens on the accept edge, before the latches load.
  assign cur_we    = (state_q == ST_IDLE) ? we_i    : we_q;
  assign cur_addr  = (state_q == ST_IDLE) ? addr_i  : addr_q;
  assign cur_wdata = (state_q == ST_IDLE) ? wdata_i : wdata_q;
  assign cur_err   = (cur_addr[BYTE_OFF_W-1:0] != '0) ||
                     ({1'b0, cur_addr[WORD_W-1:BYTE_OFF_W]} >= DEPTH_LIM);

  assign mem_we = enter_resp && cur_we && !cur_err && !rst_i;

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .IDX_W      (IDX_W)
  ) u_array (
    .clk_i  (clk_i),
    .we_i   (mem_we),
    .idx_i  (cur_addr[IDX_W+BYTE_OFF_W-1:BYTE_OFF_W]),
    .wdata_i(cur_wdata),
    .rdata_o(mem_rdata)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    enter_resp = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          we_d    = we_i;
          addr_d  = addr_i;
          wdata_d = wdata_i;
          cnt_d   = CNT_LOAD;
          if (LATENCY == 1) begin
            state_d    = ST_RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_d == 8'd0) begin
          state_d    = ST_RESP;
          enter_resp = 1'b1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    ready_d  = (state_d == ST_IDLE);
    rvalid_d = enter_resp;
    err_d    = enter_resp && cur_err;
    rdata_d  = (enter_resp && !cur_we && !cur_err) ? mem_rdata : 32'd0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 8'd0;
      ready_q  <= 1'b1;
      rvalid_q <= 1'b0;
      rdata_q  <= 32'd0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ready_q  <= ready_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  always_ff @(posedge clk_i) begin
    we_q    <= we_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end

  assign ready_o  = ready_q;
  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;
  assign err_o    = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder against a word-array reference model;
// a second instance with LATENCY=1 covers back-to-back accepts.
module tb_dmem_responder;

  localparam int LAT   = 4;
  localparam int DEPTH = 256;
  localparam int NW    = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        req, we;
  logic [31:0] addr, wdata;
  logic        ready, rvalid, err;
  logic [31:0] rdata;
  logic        req1, we1;
  logic [31:0] addr1, wdata1;
  logic        ready1, rvalid1, err1;
  logic [31:0] rdata1;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] model_mem [NW];

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) u_dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .addr_i(addr),
    .wdata_i(wdata), .ready_o(ready), .rvalid_o(rvalid), .rdata_o(rdata), .err_o(err)
  );

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1)) u_dut_l1 (
    .clk_i(clk), .rst_i(rst), .req_i(req1), .we_i(we1), .addr_i(addr1),
    .wdata_i(wdata1), .ready_o(ready1), .rvalid_o(rvalid1), .rdata_o(rdata1), .err_o(err1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic model_err(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a[31:2] >= 30'(DEPTH));
  endfunction

  // One full transaction on the LATENCY=4 instance, checked against the model.
  task automatic xact(input logic w, input logic [31:0] a, input logic [31:0] d);
    logic        e;
    logic [31:0] exp_rd, cap_rd;
    logic        cap_err;
    int          idx, waited, first_k, nv;
    e      = model_err(a);
    idx    = int'(a[31:2]);
    exp_rd = (!w && !e && idx < NW) ? model_mem[idx] : 32'd0;
    cap_rd = 32'hFFFF_FFFF;
    cap_err = 1'b0;
    first_k = -1;
    nv = 0;
    @(negedge clk);
    req = 1'b1; we = w; addr = a; wdata = d;
    waited = 0;
    while (!ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!ready) begin
      check("ready_wait", 32'd0, 32'd1);
      req = 1'b0;
      return;
    end
    @(posedge clk);
    #1 req = 1'b0;
    for (int k = 1; k <= LAT + 2; k++) begin
      @(negedge clk);
      check("ready", 32'(ready), 32'(k > LAT));
      if (rvalid) begin
        nv++;
        if (first_k < 0) begin
          first_k = k;
          cap_rd  = rdata;
          cap_err = err;
        end
      end else begin
        check("idle_rdata", rdata, 32'd0);
        check("idle_err", 32'(err), 32'd0);
      end
    end
    check("rv_count", 32'(nv), 32'd1);
    check("latency", 32'(first_k), 32'(LAT));
    check("rdata", cap_rd, exp_rd);
    check("err", 32'(cap_err), 32'(e));
    if (w && !e && idx < NW) model_mem[idx] = d;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    int cat;
    rst = 1'b1;
    req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_ready_l1", 32'(ready1), 32'd1);

    for (int i = 0; i < NW; i++) xact(1'b1, 32'(i * 4), $urandom);

    xact(1'b1, 32'h10, 32'hDEAD_BEEF);
    xact(1'b0, 32'h10, 32'h0);
    check("raw_model", model_mem[4], 32'hDEAD_BEEF);
    xact(1'b0, 32'h13, 32'h0);
    xact(1'b1, 32'h400, 32'hCAFE_F00D);
    xact(1'b0, 32'h0, 32'h0);

    // Reset lands while the store is still waiting; it must vanish.
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'h1234_5678;
    @(posedge clk);
    #1 req = 1'b0;
    @(negedge clk);
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    check("mid_rst_ready", 32'(ready), 32'd1);
    for (int k = 0; k < LAT + 2; k++) begin
      check("mid_rst_rvalid", 32'(rvalid), 32'd0);
      @(negedge clk);
    end
    xact(1'b0, 32'h20, 32'h0);

    for (int n = 0; n < 40; n++) begin
      cat = $urandom_range(3, 0);
      case (cat)
        0, 1: a = 32'($urandom_range(NW - 1, 0)) << 2;
        2:    a = (32'($urandom_range(NW - 1, 0)) << 2) | 32'($urandom_range(3, 1));
        default: a = {30'($urandom_range(32'h3FFF_FFFF, DEPTH)), 2'b00};
      endcase
      xact(1'($urandom_range(1, 0)), a, $urandom);
    end

    // Held request on the LATENCY=1 instance: accept every other cycle.
    @(negedge clk);
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'h3; wdata1 = '0;
    for (int i = 0; i < 8; i++) begin
      check("l1_ready", 32'(ready1), 32'(i % 2 == 0));
      check("l1_rvalid", 32'(rvalid1), 32'(i % 2 == 1));
      if (rvalid1) begin
        check("l1_err", 32'(err1), 32'd1);
        check("l1_rdata", rdata1, 32'd0);
      end
      if (i < 7) @(negedge clk);
    end
    req1 = 1'b0;
    @(negedge clk);
    check("l1_idle_ready", 32'(ready1), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Multi-cycle data-memory responder: the memory-side end of the CPU's data-memory port. It accepts one load or store per handshake, holds it for a programmable access latency, then returns a single-cycle response carrying read data or an error flag. It replaces the zero-latency data memory behind the MEM stage, so the pipeline's stall logic can be exercised against a realistic slow memory.

## Interface
- `DEPTH_WORDS`, default 256: number of 32-bit words in the array; legal range 1..2^30.
- `LATENCY`, default 4: cycles from accept to response; legal range 1..255.
- `clk_i` input, 1 bit: the single clock. All state changes on its rising edge.
- `rst_i` input, 1 bit: reset, synchronous and active-high.
- `req_i` input, 1 bit: request valid. Must stay high with stable fields until accepted.
- `we_i` input, 1 bit: 1 = store, 0 = load.
- `addr_i` input, 32 bits: byte address.
- `wdata_i` input, 32 bits: store data.
- `ready_o` output, 1 bit: the responder can accept a request this cycle.
- `rvalid_o` output, 1 bit: one-cycle response strobe.
- `rdata_o` output, 32 bits: load data, valid while `rvalid_o` is high.
- `err_o` output, 1 bit: the access was rejected, valid while `rvalid_o` is high.

## Operation
- **Accept.** A request is accepted on an edge where `req_i` and `ready_o` are both 1. On accept, latch `we_i`, `addr_i` and `wdata_i`, and load the counter with LATENCY-1.
- **IDLE.** `ready_o`=1. On accept go to WAIT; if LATENCY=1, go straight to RESP.
- **WAIT.** `ready_o`=0. Decrement the counter each cycle. When the counter reaches 0, go to RESP on that same edge.
- **RESP.** Lasts one cycle, with `rvalid_o`=1 and `ready_o`=0. Return to IDLE unconditionally.
- **Memory access.** The write, or the capture of read data, happens on the edge that enters RESP.
- **Word index.** The word index is the latched `addr_i[31:2]`.
- **Error conditions.** A request is an error if `addr[1:0]`≠0 or word index ≥ DEPTH_WORDS.
- **Error response.** For an error: no array access, `err_o`=1, and `rdata_o`=0.
- **Store response.** For a store: `rdata_o`=0 and `err_o`=0.
- **Output defaults.** Outside RESP, `rdata_o`=0 and `err_o`=0.
- **Array state.** The array is not cleared by reset, and its contents persist across resets.
- **Ignored requests.** A request raised while `ready_o`=0 is ignored, not queued. The requester keeps it asserted.

## Timing
- **Reset values.** Reset puts the FSM in IDLE with counter=0. Outputs after reset: `ready_o`=1, `rvalid_o`=0, `rdata_o`=0, `err_o`=0.
- **Reset mid-operation.** Reset in WAIT or RESP aborts the transaction: no `rvalid_o` pulse, and a pending store is dropped with the array unmodified. Reset wins over any simultaneous accept.
- **Latency.** Accept on edge N gives `rvalid_o` high for the cycle after edge N+LATENCY-1, i.e. exactly LATENCY cycles later. LATENCY=1 gives the response in the next cycle.
- **Throughput.** `ready_o` returns high in the cycle after RESP. The minimum accept-to-accept spacing is LATENCY+1 cycles.
- **Read-after-write.** A load accepted after a store's RESP sees the stored value.
- **Counter.** The counter is 8 bits wide and never wraps, since it is reloaded only on accept.
- **Word-index width.** The width is $clog2(DEPTH_WORDS). The range comparison uses the full 30-bit index, so high address bits cannot alias.

## Structure
- **Shared package `dmem_pkg`.**
  - State enum (IDLE, WAIT, RESP).
  - Word width constant 32.
  - Byte-offset width constant 2.
- **Sub-module `dmem_array`.**
  - Parameter DEPTH_WORDS.
  - Synchronous write with a write-enable.
  - Combinational read.
  - No reset.
- **Top level.** The top holds the FSM, counter, request latches and response registers.

## Test plan
- **Reset defaults.** Reset, then idle → `ready_o`=1, `rvalid_o`=0, `rdata_o`=0, `err_o`=0.
- **Store then load.** Store 0xDEADBEEF to 0x10, then load 0x10 with LATENCY=4 → each `rvalid_o` comes 4 cycles after its accept; the load returns 0xDEADBEEF with `err_o`=0.
- **Misaligned load.** Load from 0x13 → `rvalid_o` with `err_o`=1 and `rdata_o`=0.
- **Out-of-range store.** Store to 0x400 with DEPTH_WORDS=256 → `err_o`=1; a later load of 0x0 returns its prior value.
- **Latency 1, back-to-back.** LATENCY=1 with `req_i` held high for four loads → accepts every 2 cycles and `ready_o` toggles 1,0,1,0.
- **Reset mid-store.** Store 0x12345678 to 0x20, assert `rst_i` in WAIT → no `rvalid_o`; a load of 0x20 returns the old value.
